// File: rtl/cam_pingpong_writer_pkg.sv
// Shared types and constants for the camera ping-pong frame writer.
// Holds the capture state encoding, decimation codes and the decimation grid helper.
package cam_pkg;

  typedef enum logic [1:0] {
    CAP_IDLE,
    CAP_WAIT_VS,
    CAP_ACTIVE,
    CAP_HOLD
  } cap_state_e;

  localparam logic [1:0] DEC_1_1  = 2'd0;
  localparam logic [1:0] DEC_1_2  = 2'd1;
  localparam logic [1:0] DEC_1_4  = 2'd2;
  localparam logic [1:0] DEC_RSVD = 2'd3;

  localparam int DROP_W = 8;

  // The reserved code behaves like 1:4.
  function automatic logic [1:0] dec_to_k(input logic [1:0] dec);
    return (dec == DEC_RSVD) ? DEC_1_4 : dec;
  endfunction

  // True when the low k bits of a coordinate are zero (k is at most 2).
  function automatic logic on_grid(input logic [1:0] low, input logic [1:0] k);
    logic [1:0] mask;
    case (k)
      DEC_1_1: mask = 2'b00;
      DEC_1_2: mask = 2'b01;
      default: mask = 2'b11;
    endcase
    return (low & mask) == 2'b00;
  endfunction

endpackage

// File: rtl/cam_pingpong_writer_if.sv
// Frame-RAM write port driven by the camera writer; the MSB of wraddr selects the bank.
interface cam_wr_if #(
  parameter int PIX_W  = 3,
  parameter int ADDR_W = 16
);
  logic [PIX_W-1:0] wrdata;
  logic [ADDR_W:0]  wraddr;
  logic             wren;

  modport master (output wrdata, wraddr, wren);
  modport slave  (input  wrdata, wraddr, wren);
endinterface

// File: rtl/cam_sync_edge.sv
// Two-flop synchronizer for one asynchronous camera signal, with single-cycle
// rise/fall pulses taken from the synchronized level.
module cam_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic level,
  output logic rise,
  output logic fall
);
  logic meta;
  logic sync;
  logic sync_d;

  // NOTE: non-blocking assignments make these three registers a true shift chain;
  // blocking ones would collapse it into a single flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta   <= 1'b0;
      sync   <= 1'b0;
      sync_d <= 1'b0;
    end else begin
      meta   <= async_in;
      sync   <= meta;
      sync_d <= sync;
    end
  end

  assign level = sync;
  assign rise  = sync & ~sync_d;
  assign fall  = ~sync & sync_d;
endmodule

// File: rtl/cam_pingpong_writer.sv
// Camera-to-frame-buffer writer: captures decimated frames into one RAM bank while the
// reader scans the other, swapping banks only on a reader frame boundary.
module cam_pingpong_writer
  import cam_pkg::*;
#(
  parameter int PIX_W   = 3,
  parameter int ADDR_W  = 16,
  parameter int H_PIX   = 256,
  parameter int V_LINES = 240
) (
  input  logic              sysclk,
  input  logic              resetc,
  input  logic              pclk,
  input  logic              vsync,
  input  logic              href,
  input  logic [PIX_W-1:0]  d,
  input  logic              cap_en,
  input  logic [1:0]        dec,
  input  logic              rd_frame_start,
  cam_wr_if.master          wr,
  output logic              rd_bank,
  output logic              frame_done,
  output logic              short_err,
  output logic [DROP_W-1:0] drop_cnt
);
  // One spare bit lets x and y saturate at H_PIX / V_LINES instead of wrapping.
  localparam int X_W = $clog2(H_PIX) + 1;
  localparam int Y_W = $clog2(V_LINES) + 1;
  localparam logic [X_W-1:0]    X_END    = X_W'(H_PIX);
  localparam logic [Y_W-1:0]    Y_END    = Y_W'(V_LINES);
  localparam logic [DROP_W-1:0] DROP_MAX = {DROP_W{1'b1}};

  logic pclk_lvl, pclk_rise, pclk_fall;
  logic vs_lvl, vs_rise, vs_fall;
  logic href_lvl, href_rise, href_fall;

  cam_sync_edge u_pclk_sync (
    .clk(sysclk), .rst_n(resetc), .async_in(pclk),
    .level(pclk_lvl), .rise(pclk_rise), .fall(pclk_fall)
  );
  cam_sync_edge u_vsync_sync (
    .clk(sysclk), .rst_n(resetc), .async_in(vsync),
    .level(vs_lvl), .rise(vs_rise), .fall(vs_fall)
  );
  cam_sync_edge u_href_sync (
    .clk(sysclk), .rst_n(resetc), .async_in(href),
    .level(href_lvl), .rise(href_rise), .fall(href_fall)
  );

  logic unused_sync;
  assign unused_sync = &{1'b0, pclk_lvl, pclk_fall, vs_lvl, href_rise};

  // Pixel data follows the same two-stage path as pclk so both line up at the rise pulse.
  logic [PIX_W-1:0] d_meta, d_q;
  always_ff @(posedge sysclk or negedge resetc) begin
    if (!resetc) begin
      d_meta <= '0;
      d_q    <= '0;
    end else begin
      d_meta <= d;
      d_q    <= d_meta;
    end
  end

  cap_state_e       state;
  logic [1:0]       k;
  logic [X_W-1:0]   x;
  logic [Y_W-1:0]   y;
  logic [ADDR_W-1:0] addr;
  logic             wbank;
  logic             fresh;

  logic commit, swap, pix_ok;
  assign commit = (state == CAP_ACTIVE) && vs_rise && (y == Y_END);
  assign swap   = rd_frame_start && (fresh || commit);
  assign pix_ok = (x < X_END) && (y < Y_END) && on_grid(x[1:0], k) && on_grid(y[1:0], k);

  assign rd_bank = ~wbank;

  always_ff @(posedge sysclk or negedge resetc) begin
    if (!resetc) begin
      state      <= CAP_IDLE;
      k          <= DEC_1_1;
      x          <= '0;
      y          <= '0;
      addr       <= '0;
      wbank      <= 1'b0;
      fresh      <= 1'b0;
      drop_cnt   <= '0;
      wr.wren    <= 1'b0;
      wr.wrdata  <= '0;
      wr.wraddr  <= '0;
      frame_done <= 1'b0;
      short_err  <= 1'b0;
    end else begin
      wr.wren    <= 1'b0;
      frame_done <= 1'b0;
      short_err  <= 1'b0;

      // A swap toggles the write bank in whatever state it lands; a commit in the
      // same cycle is consumed immediately rather than leaving fresh set.
      if (swap) begin
        wbank <= ~wbank;
        fresh <= 1'b0;
      end else if (commit) begin
        fresh <= 1'b1;
      end

      case (state)
        CAP_IDLE: begin
          if (cap_en) state <= CAP_WAIT_VS;
        end

        CAP_WAIT_VS: begin
          if (!cap_en) begin
            state <= CAP_IDLE;
          end else if (vs_fall) begin
            k     <= dec_to_k(dec);
            x     <= '0;
            y     <= '0;
            addr  <= '0;
            state <= CAP_ACTIVE;
          end
        end

        CAP_ACTIVE: begin
          if (vs_rise) begin
            if (commit) begin
              frame_done <= 1'b1;
              state      <= swap ? CAP_WAIT_VS : CAP_HOLD;
            end else begin
              short_err <= 1'b1;
              state     <= CAP_WAIT_VS;
            end
            if (!cap_en) state <= CAP_IDLE;
          end else begin
            if (pclk_rise && href_lvl) begin
              if (pix_ok) begin
                wr.wren   <= 1'b1;
                wr.wrdata <= d_q;
                wr.wraddr <= {wbank, addr};
                addr      <= addr + 1'b1;
              end
              if (x != X_END) x <= x + 1'b1;
            end
            if (href_fall) begin
              x <= '0;
              if (y != Y_END) y <= y + 1'b1;
            end
          end
        end

        CAP_HOLD: begin
          if (vs_fall && drop_cnt != DROP_MAX) drop_cnt <= drop_cnt + 1'b1;
          if (!cap_en)   state <= CAP_IDLE;
          else if (swap) state <= CAP_WAIT_VS;
        end

        default: state <= CAP_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cam_pingpong_writer.sv
// Self-checking bench for cam_pingpong_writer: drives camera frames and compares every
// RAM write and control output against a frame-level model of the capture rules.
module tb_cam_pingpong_writer;
  localparam int PIX_W   = 3;
  localparam int ADDR_W  = 8;
  localparam int H_PIX   = 16;
  localparam int V_LINES = 12;

  logic             sysclk = 1'b0;
  logic             resetc = 1'b0;
  logic             pclk = 1'b0, vsync = 1'b1, href = 1'b0;
  logic [PIX_W-1:0] d = '0;
  logic             cap_en = 1'b0;
  logic [1:0]       dec = 2'd0;
  logic             rd_frame_start = 1'b0;
  logic             rd_bank, frame_done, short_err;
  logic [7:0]       drop_cnt;

  cam_wr_if #(.PIX_W(PIX_W), .ADDR_W(ADDR_W)) wr_bus ();

  cam_pingpong_writer #(
    .PIX_W(PIX_W), .ADDR_W(ADDR_W), .H_PIX(H_PIX), .V_LINES(V_LINES)
  ) dut (
    .sysclk(sysclk), .resetc(resetc), .pclk(pclk), .vsync(vsync), .href(href),
    .d(d), .cap_en(cap_en), .dec(dec), .rd_frame_start(rd_frame_start),
    .wr(wr_bus), .rd_bank(rd_bank), .frame_done(frame_done),
    .short_err(short_err), .drop_cnt(drop_cnt)
  );

  always #5 sysclk = ~sysclk;

  typedef struct packed {
    logic [ADDR_W:0]  addr;
    logic [PIX_W-1:0] data;
  } wr_t;

  int  n_checks = 0;
  int  n_fail = 0;
  wr_t exp_q[$];
  wr_t obs_log[$];
  bit  m_en = 0, m_hold = 0, m_fresh = 0, m_wbank = 0;
  int  m_drop = 0;
  bit  exp_rd_bank = 1;
  bit  frame_cap = 0;
  int  fd_cnt = 0, se_cnt = 0, exp_fd = 0, exp_se = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Every cycle: bank output and each RAM write against the expected write stream.
  always @(negedge sysclk) begin
    wr_t got, e;
    if (resetc) begin
      check("rd_bank", rd_bank, exp_rd_bank);
      if (wr_bus.wren) begin
        got.addr = wr_bus.wraddr;
        got.data = wr_bus.wrdata;
        obs_log.push_back(got);
        if (exp_q.size() == 0) begin
          check("wren_unexpected", wr_bus.wren, 0);
        end else begin
          e = exp_q.pop_front();
          check("wraddr", got.addr, e.addr);
          check("wrdata", got.data, e.data);
        end
      end
      if (frame_done) fd_cnt++;
      if (short_err)  se_cnt++;
    end
  end

  function automatic logic [PIX_W-1:0] pix_val(int pat, int seed, int x, int y);
    case (pat)
      0:       return PIX_W'(x);
      1:       return PIX_W'(x + y);
      default: return PIX_W'(x * 5 + y * 3 + seed);
    endcase
  endfunction

  function automatic void m_swap();
    m_wbank     = ~m_wbank;
    m_fresh     = 0;
    m_hold      = 0;
    exp_rd_bank = ~m_wbank;
  endfunction

  task automatic tick(int n);
    repeat (n) @(posedge sysclk);
    #1;
  endtask

  task automatic set_cap(bit v);
    cap_en = v;
    m_en   = v;
    if (!v) m_hold = 0;
    tick(3);
  endtask

  task automatic pulse_rfs();
    rd_frame_start = 1'b1;
    tick(1);
    rd_frame_start = 1'b0;
    if (m_fresh) m_swap();
    tick(2);
  endtask

  task automatic do_reset();
    resetc = 1'b0;
    #1;
    check("reset_wren", wr_bus.wren, 0);
    check("reset_rd_bank", rd_bank, 1);
    check("reset_drop_cnt", drop_cnt, 0);
    check("reset_frame_done", frame_done, 0);
    exp_q.delete();
    frame_cap   = 0;
    m_hold      = 0;
    m_fresh     = 0;
    m_wbank     = 0;
    m_drop      = 0;
    exp_rd_bank = 1;
    tick(3);
    resetc = 1'b1;
  endtask

  task automatic drive_frame(int lines, int pix, int pat, bit swap_at_commit,
                             int rst_line, int rst_pix);
    int seed, step, addr;
    seed = $urandom_range(0, 7);
    obs_log.delete();
    frame_cap = 0;
    if (m_en && !m_hold) frame_cap = 1;
    else if (m_en && m_hold && m_drop < 255) m_drop++;
    step = 1 << ((dec == 2'd3) ? 2 : int'(dec));
    if (frame_cap) begin
      addr = 0;
      for (int y = 0; y < lines; y++)
        for (int x = 0; x < pix; x++)
          if (x < H_PIX && y < V_LINES && x % step == 0 && y % step == 0) begin
            wr_t e;
            e.addr = {m_wbank, ADDR_W'(addr)};
            e.data = pix_val(pat, seed, x, y);
            exp_q.push_back(e);
            addr++;
          end
    end

    vsync = 1'b0;
    tick($urandom_range(3, 6));
    for (int y = 0; y < lines; y++) begin
      href = 1'b1;
      for (int x = 0; x < pix; x++) begin
        if (y == rst_line && x == rst_pix) do_reset();
        d    = pix_val(pat, seed, x, y);
        pclk = 1'b0;
        tick($urandom_range(2, 3));
        pclk = 1'b1;
        tick($urandom_range(2, 3));
      end
      pclk = 1'b0;
      tick(2);
      href = 1'b0;
      tick($urandom_range(3, 5));
    end

    // Frame end: outputs respond three sysclk cycles after the vsync pin rises.
    vsync = 1'b1;
    tick(2);
    if (swap_at_commit) rd_frame_start = 1'b1;
    tick(1);
    rd_frame_start = 1'b0;
    if (frame_cap && lines >= V_LINES) begin
      check("frame_done_pulse", frame_done, 1);
      check("short_err_quiet", short_err, 0);
      exp_fd++;
      m_fresh = 1;
      m_hold  = 1;
    end else if (frame_cap) begin
      check("short_err_pulse", short_err, 1);
      check("frame_done_quiet", frame_done, 0);
      exp_se++;
    end else begin
      check("frame_done_idle", frame_done, 0);
      check("short_err_idle", short_err, 0);
    end
    if (swap_at_commit && m_fresh) m_swap();
    frame_cap = 0;
    tick(4);
    check("writes_left", exp_q.size(), 0);
    check("drop_cnt", drop_cnt, m_drop);
    check("frame_done_count", fd_cnt, exp_fd);
    check("short_err_count", se_cnt, exp_se);
  endtask

  initial begin
    tick(3);
    resetc = 1'b1;
    tick(2);
    check("init_wren", wr_bus.wren, 0);
    check("init_wraddr", wr_bus.wraddr, 0);
    check("init_wrdata", wr_bus.wrdata, 0);
    check("init_rd_bank", rd_bank, 1);
    check("init_frame_done", frame_done, 0);
    check("init_short_err", short_err, 0);
    check("init_drop_cnt", drop_cnt, 0);

    // Full-resolution frame into bank 0.
    set_cap(1);
    dec = 2'd0;
    drive_frame(V_LINES, H_PIX, 0, 0, -1, -1);
    check("full_write_count", obs_log.size(), H_PIX * V_LINES);
    check("full_last_addr", obs_log[$].addr, H_PIX * V_LINES - 1);
    check("full_last_data", obs_log[$].data, 7);
    check("full_rd_bank", rd_bank, 1);

    // Second frame with no swap is dropped.
    drive_frame(V_LINES, H_PIX, 2, 0, -1, -1);
    check("drop_no_writes", obs_log.size(), 0);
    check("drop_cnt_one", drop_cnt, 1);
    pulse_rfs();
    check("swap_rd_bank", rd_bank, 0);

    // 1:4 decimation into bank 1.
    dec = 2'd2;
    drive_frame(V_LINES, H_PIX, 1, 0, -1, -1);
    check("dec4_count", obs_log.size(), 12);
    check("dec4_row4_addr", obs_log[4].addr, (1 << ADDR_W) | 4);
    check("dec4_row4_data", obs_log[4].data, 4);
    check("dec4_last_addr", obs_log[$].addr, (1 << ADDR_W) + 11);

    // Short frame, then a full frame restarting at address 0 of bank 0.
    pulse_rfs();
    dec = 2'd0;
    drive_frame(5, H_PIX, 0, 0, -1, -1);
    check("short_err_total", se_cnt, 1);
    check("short_no_done", fd_cnt, 2);
    drive_frame(V_LINES, H_PIX, 0, 0, -1, -1);
    check("after_short_first_addr", obs_log[0].addr, 0);
    check("after_short_count", obs_log.size(), H_PIX * V_LINES);

    // Commit and swap in the same cycle.
    pulse_rfs();
    dec = 2'd3;
    drive_frame(V_LINES, H_PIX, 2, 1, -1, -1);
    check("simul_rd_bank", rd_bank, 1);
    check("simul_drop_same", drop_cnt, 1);
    dec = 2'd0;
    drive_frame(2, H_PIX, 0, 0, -1, -1);
    check("simul_next_first_addr", obs_log[0].addr, 0);
    check("simul_next_count", obs_log.size(), 2 * H_PIX);

    // Drop counter saturation.
    drive_frame(V_LINES, 0, 0, 0, -1, -1);
    for (int i = 0; i < 260; i++) drive_frame(0, 0, 0, 0, -1, -1);
    check("drop_saturated", drop_cnt, 255);

    // Disable while holding; swap still honoured in idle.
    set_cap(0);
    drive_frame(V_LINES, H_PIX, 0, 0, -1, -1);
    check("disabled_no_writes", obs_log.size(), 0);
    pulse_rfs();
    check("disabled_swap_rd_bank", rd_bank, 0);
    set_cap(1);

    // Reset in the middle of a line.
    drive_frame(V_LINES, H_PIX, 2, 0, 6, 5);
    check("post_reset_rd_bank", rd_bank, 1);
    check("post_reset_drop", drop_cnt, 0);
    drive_frame(V_LINES, H_PIX, 0, 0, -1, -1);
    check("post_reset_first_addr", obs_log[0].addr, 0);
    check("post_reset_count", obs_log.size(), H_PIX * V_LINES);

    // Randomized frames against the model.
    for (int i = 0; i < 10; i++) begin
      set_cap($urandom_range(0, 7) != 0);
      dec = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) pulse_rfs();
      drive_frame($urandom_range(V_LINES - 3, V_LINES + 2), $urandom_range(H_PIX - 2, H_PIX + 3),
                  2, $urandom_range(0, 3) == 0, -1, -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
